// File: rtl/fetch_aligner_pkg.sv
// rtl/fetch_aligner_pkg.sv - types, constants and length helper for the fetch aligner
`include "riscv_defines.v"
package fetch_aligner_pkg;

    localparam int unsigned WORD_W   = `RISCV_WORD_WIDTH;
    localparam int unsigned HALF_W   = `RISCV_HALF_WIDTH;
    localparam int unsigned HW_DEPTH = 4;

    localparam logic [WORD_W-1:0] PC_STEP_C = WORD_W'(2);
    localparam logic [WORD_W-1:0] PC_STEP_W = WORD_W'(4);

    typedef logic [HALF_W-1:0] half_t;

    // Number of halfwords moved by the buffer in one cycle
    typedef enum logic [1:0] {
        AMT_NONE = 2'd0,
        AMT_ONE  = 2'd1,
        AMT_TWO  = 2'd2
    } amt_e;

    // A halfword starts a compressed instruction unless its low bits mark a 32-bit one
    function automatic logic is_rvc(input half_t hw);
        return hw[1:0] != `RVC_LEN_32;
    endfunction

endpackage

// File: rtl/fetch_aligner_if.sv
// rtl/fetch_aligner_if.sv - fetch, redirect and instruction handshake bundle
`include "riscv_defines.v"
interface fetch_aligner_if;
    logic [`RISCV_WORD_WIDTH-1:0] fetch_data_i;
    logic                         fetch_valid_i;
    logic                         fetch_ready_o;
    logic                         redirect_i;
    logic [`RISCV_WORD_WIDTH-1:0] redirect_pc_i;
    logic [`RISCV_WORD_WIDTH-1:0] instr_o;
    logic [`RISCV_WORD_WIDTH-1:0] instr_pc_o;
    logic                         instr_valid_o;
    logic                         instr_ready_i;

    modport slave (
        input  fetch_data_i, fetch_valid_i, redirect_i, redirect_pc_i, instr_ready_i,
        output fetch_ready_o, instr_o, instr_pc_o, instr_valid_o
    );

    modport master (
        output fetch_data_i, fetch_valid_i, redirect_i, redirect_pc_i, instr_ready_i,
        input  fetch_ready_o, instr_o, instr_pc_o, instr_valid_o
    );
endinterface

// File: rtl/fetch_aligner_hwbuf.sv
// rtl/fetch_aligner_hwbuf.sv - four-halfword shift/append buffer with occupancy count
module fetch_aligner_hwbuf
    import fetch_aligner_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  amt_e              shift_i,
    input  amt_e              append_i,
    input  logic [WORD_W-1:0] word_i,
    output half_t             hw0_o,
    output half_t             hw1_o,
    output logic [2:0]        hw_cnt_o
);

    half_t      hw_q [HW_DEPTH];
    half_t      hw_d [HW_DEPTH];
    half_t      shifted [HW_DEPTH];
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [2:0] cnt_shifted;

    // Drop consumed halfwords first, then append the new ones at the post-shift count
    always_comb begin
        cnt_shifted = cnt_q - {1'b0, shift_i};
        case (shift_i)
            AMT_ONE: shifted = '{hw_q[1], hw_q[2], hw_q[3], '0};
            AMT_TWO: shifted = '{hw_q[2], hw_q[3], '0, '0};
            default: shifted = hw_q;
        endcase
        hw_d = shifted;
        for (int i = 0; i < HW_DEPTH; i++) begin
            if (append_i == AMT_TWO) begin
                if (3'(i) == cnt_shifted)        hw_d[i] = word_i[HALF_W-1:0];
                if (3'(i) == cnt_shifted + 3'd1) hw_d[i] = word_i[WORD_W-1:HALF_W];
            end else if (append_i == AMT_ONE && 3'(i) == cnt_shifted) begin
                hw_d[i] = word_i[WORD_W-1:HALF_W];
            end
        end
        cnt_d = cnt_shifted + {1'b0, append_i};
        if (flush_i) begin
            hw_d  = '{default: '0};
            cnt_d = 3'd0;
        end
    end

    // Buffer contents and count registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hw_q  <= '{default: '0};
            cnt_q <= 3'd0;
        end else begin
            hw_q  <= hw_d;
            cnt_q <= cnt_d;
        end
    end

    assign hw0_o    = hw_q[0];
    assign hw1_o    = hw_q[1];
    assign hw_cnt_o = cnt_q;

endmodule

// File: rtl/riscv_defines.v
// rtl/riscv_defines.v - shared RISC-V width and opcode-length macros
`ifndef RISCV_DEFINES_V
`define RISCV_DEFINES_V
`define RISCV_WORD_WIDTH 32
`define RISCV_HALF_WIDTH 16
`define RVC_LEN_32 2'b11
`endif

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - fetch-word to instruction aligner; FETCH_ALIGNER_RVC_EN enables 16-bit instructions
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk_i,
    input logic            rst_i,
    fetch_aligner_if.slave bus
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic              drop_lo_q;
    logic              drop_lo_d;
    half_t             hw0;
    half_t             hw1;
    logic [2:0]        hw_cnt;
    logic              is_c;
    logic              instr_valid;
    logic              consume;
    logic              accept;
    amt_e              shift_amt;
    amt_e              append_amt;
    logic [WORD_W-1:0] redirect_pc_aligned;
    logic              redirect_drop;
    logic              unused_rpc_lsbs;

`ifdef FETCH_ALIGNER_RVC_EN
    assign is_c                = is_rvc(hw0);
    assign redirect_pc_aligned = {bus.redirect_pc_i[WORD_W-1:1], 1'b0};
    assign redirect_drop       = bus.redirect_pc_i[1];
`else
    assign is_c                = 1'b0;
    assign redirect_pc_aligned = {bus.redirect_pc_i[WORD_W-1:2], 2'b00};
    assign redirect_drop       = 1'b0;
`endif
    assign unused_rpc_lsbs = ^bus.redirect_pc_i[1:0];

    assign instr_valid = (is_c && hw_cnt >= 3'd1) || hw_cnt >= 3'd2;
    assign consume     = instr_valid && bus.instr_ready_i && !bus.redirect_i;
    assign accept      = bus.fetch_valid_i && bus.fetch_ready_o && !bus.redirect_i;

    assign bus.fetch_ready_o = hw_cnt <= 3'd2;
    assign bus.instr_valid_o = instr_valid;
    assign bus.instr_o       = is_c ? {{HALF_W{1'b0}}, hw0} : {hw1, hw0};
    assign bus.instr_pc_o    = pc_q;

    // Translate the two handshakes into buffer shift and append amounts
    always_comb begin
        shift_amt  = AMT_NONE;
        append_amt = AMT_NONE;
        if (consume) begin
            if (is_c) shift_amt = AMT_ONE;
            else      shift_amt = AMT_TWO;
        end
        if (accept) begin
            if (drop_lo_q) append_amt = AMT_ONE;
            else           append_amt = AMT_TWO;
        end
    end

    // Next PC and drop-low-halfword flag; redirect overrides everything
    always_comb begin
        pc_d      = pc_q;
        drop_lo_d = drop_lo_q;
        if (bus.redirect_i) begin
            pc_d      = redirect_pc_aligned;
            drop_lo_d = redirect_drop;
        end else begin
            if (consume) pc_d = pc_q + (is_c ? PC_STEP_C : PC_STEP_W);
            if (accept)  drop_lo_d = 1'b0;
        end
    end

    // PC and drop flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            drop_lo_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            drop_lo_q <= drop_lo_d;
        end
    end

    fetch_aligner_hwbuf u_hwbuf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (bus.redirect_i),
        .shift_i  (shift_amt),
        .append_i (append_amt),
        .word_i   (bus.fetch_data_i),
        .hw0_o    (hw0),
        .hw1_o    (hw1),
        .hw_cnt_o (hw_cnt)
    );

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - self-checking bench for fetch_aligner against a halfword-queue model
module tb_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic        mdrop;

    always #5 clk = ~clk;

    fetch_aligner_if bus();

    fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic m_is_c();
`ifdef FETCH_ALIGNER_RVC_EN
        return (mq.size() > 0) && (mq[0][1:0] != 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_valid();
        return (m_is_c() && mq.size() >= 1) || mq.size() >= 2;
    endfunction

    function automatic logic [31:0] m_instr();
        if (m_is_c()) return {16'h0000, mq[0]};
        if (mq.size() >= 2) return {mq[1], mq[0]};
        return 32'h0;
    endfunction

    function automatic logic m_ready();
        return mq.size() <= 2;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 1) == 0) w[1:0] = 2'b11;
        if ($urandom_range(0, 1) == 0) w[17:16] = 2'b11;
        return w;
    endfunction

    task automatic drive(input logic fv, input logic [31:0] fd, input logic rdy,
                         input logic redir, input logic [31:0] rpc);
        bus.fetch_valid_i = fv;
        bus.fetch_data_i  = fd;
        bus.instr_ready_i = rdy;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
    endtask

    // Advance one clock and apply the spec's rules to the model queue
    task automatic tick();
        logic v, c, r;
        v = m_valid();
        c = m_is_c();
        r = m_ready();
        @(posedge clk);
        if (bus.redirect_i) begin
            mq.delete();
`ifdef FETCH_ALIGNER_RVC_EN
            mpc   = {bus.redirect_pc_i[31:1], 1'b0};
            mdrop = bus.redirect_pc_i[1];
`else
            mpc   = {bus.redirect_pc_i[31:2], 2'b00};
            mdrop = 1'b0;
`endif
        end else begin
            if (v && bus.instr_ready_i) begin
                mpc = mpc + (c ? 32'd2 : 32'd4);
                void'(mq.pop_front());
                if (!c) void'(mq.pop_front());
            end
            if (bus.fetch_valid_i && r) begin
                if (mdrop) begin
                    mq.push_back(bus.fetch_data_i[31:16]);
                    mdrop = 1'b0;
                end else begin
                    mq.push_back(bus.fetch_data_i[15:0]);
                    mq.push_back(bus.fetch_data_i[31:16]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0);
        mq.delete();
        mpc   = RESET_PC;
        mdrop = 1'b0;
        #2;
        n_cmp++;
        if (bus.instr_valid_o !== 1'b0 || bus.fetch_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hs: valid=%b ready=%b want 0 1", bus.instr_valid_o, bus.fetch_ready_o);
        end
        n_cmp++;
        if (bus.instr_o !== 32'h0 || bus.instr_pc_o !== RESET_PC) begin
            n_bad++;
            $display("FAIL reset_out: instr=%h pc=%h want 0 %h", bus.instr_o, bus.instr_pc_o, RESET_PC);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        drive(1, 32'h00A0_0093, 1, 0, 32'h0);
        #1;
        n_cmp++;
        if (bus.instr_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_bypass: valid=%b want 0", bus.instr_valid_o);
        end
        tick();
        drive(1, 32'h0010_0073, 1, 0, 32'h0);
        #1;
        n_cmp++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h00A0_0093 || bus.instr_pc_o !== 32'h100) begin
            n_bad++;
            $display("FAIL stream_first: v=%b instr=%h pc=%h want 1 00a00093 00000100",
                     bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
        end
        tick();
        drive(0, 32'h0, 1, 0, 32'h0);
        #1;
        n_cmp++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h0010_0073 || bus.instr_pc_o !== 32'h104) begin
            n_bad++;
            $display("FAIL stream_second: v=%b instr=%h pc=%h want 1 00100073 00000104",
                     bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
        end
        tick();
        #1;
        n_cmp++;
        if (bus.instr_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_empty: valid=%b want 0", bus.instr_valid_o);
        end
    endtask

    task automatic test_rvc_words();
        logic [31:0] w [3];
        w = '{32'h4501_4585, 32'h0093_4585, 32'h4505_00A0};
        drive(0, 32'h0, 1, 1, 32'h0);
        tick();
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(1, w[i], 1, 0, 32'h0);
            else       drive(0, 32'h0, 1, 0, 32'h0);
            #1;
            n_cmp++;
            if (bus.instr_valid_o !== m_valid()) begin
                n_bad++;
                $display("FAIL rvc_valid[%0d]: got %b want %b", i, bus.instr_valid_o, m_valid());
            end
            if (m_valid()) begin
                n_cmp++;
                if (bus.instr_o !== m_instr() || bus.instr_pc_o !== mpc) begin
                    n_bad++;
                    $display("FAIL rvc_instr[%0d]: got %h@%h want %h@%h", i, bus.instr_o, bus.instr_pc_o, m_instr(), mpc);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        logic        rv [9];
        logic [31:0] rp [9];
        logic        fv [9];
        logic [31:0] fd [9];
        rv = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        rp = '{32'h0000_2002, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0};
        fv = '{0, 1, 0, 0, 0, 1, 1, 0, 0};
        fd = '{0, 32'h4505_1111, 0, 0, 0, 32'h0001_4585, 32'h4501_4501, 0, 0};
        for (int i = 0; i < 9; i++) begin
            drive(fv[i], fd[i], 1, rv[i], rp[i]);
            #1;
            n_cmp++;
            if (bus.instr_valid_o !== m_valid()) begin
                n_bad++;
                $display("FAIL redir_valid[%0d]: got %b want %b", i, bus.instr_valid_o, m_valid());
            end
            if (m_valid()) begin
                n_cmp++;
                if (bus.instr_o !== m_instr() || bus.instr_pc_o !== mpc) begin
                    n_bad++;
                    $display("FAIL redir_instr[%0d]: got %h@%h want %h@%h", i, bus.instr_o, bus.instr_pc_o, m_instr(), mpc);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        drive(0, 32'h0, 0, 1, 32'h0000_0002);
        tick();
        for (int i = 0; i < 14; i++) begin
            if (i < 5) drive(1, rand_word(), 0, 0, 32'h0);
            else       drive(0, 32'h0, 1, 0, 32'h0);
            #1;
            n_cmp++;
            if (bus.fetch_ready_o !== m_ready() || bus.instr_valid_o !== m_valid()) begin
                n_bad++;
                $display("FAIL bp_hs[%0d]: ready=%b valid=%b want %b %b", i, bus.fetch_ready_o,
                         bus.instr_valid_o, m_ready(), m_valid());
            end
            if (m_valid()) begin
                n_cmp++;
                if (bus.instr_o !== m_instr() || bus.instr_pc_o !== mpc) begin
                    n_bad++;
                    $display("FAIL bp_instr[%0d]: got %h@%h want %h@%h", i, bus.instr_o, bus.instr_pc_o, m_instr(), mpc);
                end
            end
            if (i >= 2 && i < 5) begin
                n_cmp++;
                if (bus.instr_o !== held_instr || bus.instr_pc_o !== held_pc) begin
                    n_bad++;
                    $display("FAIL bp_hold[%0d]: got %h@%h want %h@%h", i, bus.instr_o, bus.instr_pc_o, held_instr, held_pc);
                end
            end
            held_instr = bus.instr_o;
            held_pc    = bus.instr_pc_o;
            tick();
        end
    endtask

    task automatic test_collision();
        drive(0, 32'h0, 0, 1, 32'h0);
        tick();
        drive(1, 32'h00A0_0093, 0, 0, 32'h0);
        tick();
        drive(1, 32'h1234_5677, 1, 1, 32'h0000_3000);
        #1;
        n_cmp++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h00A0_0093) begin
            n_bad++;
            $display("FAIL coll_pre: v=%b instr=%h want 1 00a00093", bus.instr_valid_o, bus.instr_o);
        end
        tick();
        drive(0, 32'h0, 1, 0, 32'h0);
        #1;
        n_cmp++;
        if (bus.instr_valid_o !== 1'b0 || bus.instr_pc_o !== 32'h0000_3000 || bus.fetch_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL coll_post: v=%b pc=%h ready=%b want 0 00003000 1",
                     bus.instr_valid_o, bus.instr_pc_o, bus.fetch_ready_o);
        end
        n_cmp++;
        if (bus.instr_valid_o !== m_valid() || bus.instr_pc_o !== mpc) begin
            n_bad++;
            $display("FAIL coll_model: v=%b pc=%h want %b %h", bus.instr_valid_o, bus.instr_pc_o, m_valid(), mpc);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0, $urandom);
            #1;
            n_cmp++;
            if (bus.fetch_ready_o !== m_ready() || bus.instr_valid_o !== m_valid()) begin
                n_bad++;
                $display("FAIL rnd_hs[%0d]: ready=%b valid=%b want %b %b", i, bus.fetch_ready_o,
                         bus.instr_valid_o, m_ready(), m_valid());
            end
            if (m_valid()) begin
                n_cmp++;
                if (bus.instr_o !== m_instr() || bus.instr_pc_o !== mpc) begin
                    n_bad++;
                    $display("FAIL rnd_instr[%0d]: got %h@%h want %h@%h", i, bus.instr_o, bus.instr_pc_o, m_instr(), mpc);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1, 32'h0093_4585, 0, 0, 32'h0);
        tick();
        drive(1, 32'h4505_00A0, 0, 0, 32'h0);
        tick();
        drive(0, 32'h0, 1, 0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.instr_valid_o !== 1'b0 || bus.fetch_ready_o !== 1'b1 ||
            bus.instr_pc_o !== RESET_PC || bus.instr_o !== 32'h0) begin
            n_bad++;
            $display("FAIL async_rst: v=%b ready=%b pc=%h instr=%h want 0 1 %h 0",
                     bus.instr_valid_o, bus.fetch_ready_o, bus.instr_pc_o, bus.instr_o, RESET_PC);
        end
        mq.delete();
        mpc   = RESET_PC;
        mdrop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h0010_0073, 1, 0, 32'h0);
        tick();
        #1;
        n_cmp++;
        if (bus.instr_valid_o !== m_valid() || bus.instr_o !== m_instr() || bus.instr_pc_o !== mpc) begin
            n_bad++;
            $display("FAIL async_resume: got %b %h@%h want %b %h@%h", bus.instr_valid_o, bus.instr_o,
                     bus.instr_pc_o, m_valid(), m_instr(), mpc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_rvc_words();
        test_redirect();
        test_backpressure();
        test_collision();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
